// File: rtl/ysyx_23060184_pkg.sv
// rtl/ysyx_23060184_pkg.sv - shared encodings for the writeback unit
//
// Contents:
//   WB_*      writeback source select encodings (wb_sel)
//   F3_*      RV32I load funct3 encodings
//   wbu_state_e  writeback FSM states
package ysyx_23060184_pkg;

    // Writeback source select
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_CSR  = 2'b11;

    // RV32I load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/ysyx_23060184_ld_ext.sv
// rtl/ysyx_23060184_ld_ext.sv - load byte/halfword selection and extension
//
// Purely combinational.
// Ports:
//   word    in   DATA_WIDTH  raw aligned load word
//   offset  in   2           byte offset within the word (address[1:0])
//   funct3  in   3           RV32I load type
//   data    out  DATA_WIDTH  selected and extended load value
module ysyx_23060184_ld_ext
    import ysyx_23060184_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
    end

    // Halfword loads are assumed halfword-aligned; offset[0] is ignored.
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_wbu.sv
// rtl/ysyx_23060184_wbu.sv - writeback unit with valid/ready handshake
//
// Optional feature macro: YSYX_23060184_COMMIT_CNT_EN adds a 64-bit
// commit_cnt output counting WRITE cycles.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   Mvalid / Wready     upstream handshake (Wready high only in IDLE)
//   alu_res, mem_rdata, csr_rdata, pc, rd, rf_wen_in, wb_sel, ld_funct3
//                       memory-stage result, captured on acceptance
//   Wvalid              one-cycle writeback strobe
//   wen, waddr, wdata   register file write port
//   commit_pc           PC of the instruction written back
//   commit_cnt          (macro only) number of WRITE cycles since reset
module ysyx_23060184_wbu
    import ysyx_23060184_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  Mvalid,
    output logic                  Wready,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  rf_wen_in,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            ld_funct3,
    output logic                  Wvalid,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
`ifdef YSYX_23060184_COMMIT_CNT_EN
    output logic [63:0]           commit_cnt,
`endif
    output logic [DATA_WIDTH-1:0] commit_pc
);

    wbu_state_e            state;
    logic                  wready_q;
    logic                  wvalid_q;
    logic                  wen_q;

    // Captured copy of the upstream result; only changes on acceptance,
    // which keeps waddr/wdata/commit_pc stable between writebacks.
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] csr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [1:0]            sel_q;
    logic [2:0]            f3_q;

    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] pc_plus4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wready_q <= 1'b1;
            wvalid_q <= 1'b0;
            wen_q    <= 1'b0;
            alu_q    <= '0;
            mem_q    <= '0;
            csr_q    <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            sel_q    <= WB_ALU;
            f3_q     <= F3_LB;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Mvalid) begin
                        state    <= ST_WRITE;
                        wready_q <= 1'b0;
                        wvalid_q <= 1'b1;
                        // x0 is hardwired to zero, so never request a write to it.
                        wen_q    <= rf_wen_in && (rd != '0);
                        alu_q    <= alu_res;
                        mem_q    <= mem_rdata;
                        csr_q    <= csr_rdata;
                        pc_q     <= pc;
                        rd_q     <= rd;
                        sel_q    <= wb_sel;
                        f3_q     <= ld_funct3;
                    end
                end
                ST_WRITE: begin
                    // Mvalid is ignored here; upstream holds until Wready returns.
                    state    <= ST_IDLE;
                    wready_q <= 1'b1;
                    wvalid_q <= 1'b0;
                    wen_q    <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    wready_q <= 1'b1;
                    wvalid_q <= 1'b0;
                    wen_q    <= 1'b0;
                end
            endcase
        end
    end

    ysyx_23060184_ld_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ld_ext (
        .word   (mem_q),
        .offset (alu_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    assign pc_plus4 = pc_q + {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    // Fed only from captured registers, so there is no path from the
    // upstream inputs to wdata within a cycle.
    always_comb begin
        wdata = alu_q;
        case (sel_q)
            WB_ALU:  wdata = alu_q;
            WB_LOAD: wdata = load_data;
            WB_PC4:  wdata = pc_plus4;
            WB_CSR:  wdata = csr_q;
            default: wdata = alu_q;
        endcase
    end

    assign Wready    = wready_q;
    assign Wvalid    = wvalid_q;
    assign wen       = wen_q;
    assign waddr     = rd_q;
    assign commit_pc = pc_q;

`ifdef YSYX_23060184_COMMIT_CNT_EN
    // Counts every WRITE cycle, including writes suppressed for x0 or
    // instructions without a destination.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            commit_cnt <= 64'd0;
        end else if (state == ST_WRITE) begin
            commit_cnt <= commit_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: doc/ysyx_23060184_wbu.md
YSYX_23060184_WBU -- requirements
Module: ysyx_23060184_wbu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register/data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Mvalid  input  1  memory stage holds a valid result.
REQ-006 SHALL have port Wready  output  1  WBU can accept a result.
REQ-007 SHALL have port alu_res  input  DATA_WIDTH  ALU result / load address.
REQ-008 SHALL have port mem_rdata  input  DATA_WIDTH  raw aligned load word.
REQ-009 SHALL have port csr_rdata  input  DATA_WIDTH  CSR read value.
REQ-010 SHALL have port pc  input  DATA_WIDTH  instruction PC.
REQ-011 SHALL have port rd  input  ADDR_WIDTH  destination register.
REQ-012 SHALL have port rf_wen_in  input  1  instruction writes rd.
REQ-013 SHALL have port wb_sel  input  2  source: 00 ALU, 01 load, 10 pc+4, 11 CSR.
REQ-014 SHALL have port ld_funct3  input  3  load type (RV32I funct3).
REQ-015 SHALL have port Wvalid  output  1  writeback strobe to register file.
REQ-016 SHALL have port wen  output  1  register write enable.
REQ-017 SHALL have port waddr  output  ADDR_WIDTH  write index.
REQ-018 SHALL have port wdata  output  DATA_WIDTH  write data.
REQ-019 SHALL have port commit_pc  output  DATA_WIDTH  PC of instruction written back.

Function
REQ-020 SHALL implement FSM states IDLE and WRITE; IDLE -> WRITE on Mvalid && Wready; WRITE -> IDLE unconditionally next cycle.
REQ-021 SHALL drive Wready=1 only in IDLE; upstream data captured into internal registers on the accepting edge.
REQ-022 SHALL assert Wvalid for exactly one cycle (WRITE), one cycle after acceptance; max throughput one result per 2 cycles.
REQ-023 SHALL drive wen = captured rf_wen_in && captured rd != 0, and only while Wvalid; wen=0 in IDLE.
REQ-024 SHALL hold waddr, wdata, commit_pc stable from WRITE until next acceptance.
REQ-025 SHALL compute wdata from captured values: ALU -> alu_res; pc+4 -> pc+4 modulo 2^DATA_WIDTH; CSR -> csr_rdata; load -> extended data below.
REQ-026 SHALL select load byte by alu_res[1:0], halfword by alu_res[1]; funct3 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; any other code -> full word.
REQ-027 SHALL ignore Mvalid while in WRITE; upstream holds its result until Wready.
REQ-028 SHALL compute wdata from registered inputs only (no combinational path Mvalid/data -> Wvalid/wdata).

Reset
REQ-029 SHALL, while resetn=0, force state IDLE, Wready=1, Wvalid=0, wen=0, waddr=0, wdata=0, commit_pc=0.
REQ-030 SHALL abort an in-flight WRITE on reset assertion with no register write issued.

Configuration
REQ-031 SHALL, with YSYX_23060184_COMMIT_CNT_EN defined, add output commit_cnt (64 bit), reset 0, incremented by 1 in every WRITE cycle (wen or not), wrapping at 2^64.
REQ-032 SHALL, without YSYX_23060184_COMMIT_CNT_EN, omit the commit_cnt port and counter; all other behaviour identical.

Structure
REQ-033 SHALL place wb_sel encodings, load funct3 encodings and FSM state encodings in shared package ysyx_23060184_pkg.
REQ-034 SHALL implement load alignment/extension in sub-module ysyx_23060184_ld_ext (combinational: word, offset, funct3 -> data).

Verification
REQ-035 SHALL cover ALU write: Mvalid=1, wb_sel=00, alu_res=0x1234_5678, rd=5, rf_wen_in=1 -> next cycle Wvalid=1, wen=1, waddr=5, wdata=0x1234_5678; following cycle Wvalid=0, Wready=1.
REQ-036 SHALL cover loads: mem_rdata=0x80FF_7F01; LB off 3 -> 0xFFFF_FF80; LBU off 3 -> 0x0000_0080; LH off 2 -> 0xFFFF_80FF; LHU off 0 -> 0x0000_7F01.
REQ-037 SHALL cover x0: rd=0, rf_wen_in=1, wb_sel=00 -> Wvalid=1, wen=0.
REQ-038 SHALL cover jal link: pc=0xFFFF_FFFC, wb_sel=10 -> wdata=0x0000_0000; pc=0x8000_0000 -> 0x8000_0004.
REQ-039 SHALL cover back-to-back: Mvalid held high 4 cycles -> exactly 2 Wvalid pulses, Wready alternates 1,0,1,0.
REQ-040 SHALL cover reset mid-WRITE: resetn low in WRITE cycle -> Wvalid, wen drop immediately, Wready=1, commit_cnt=0 (macro on).
